// File: rtl/neuron_mac.sv
// neuron_mac: streams N_INPUTS signed 8x8 activation/weight products into a
// WIDTH-bit accumulator, adds the neuron bias, optionally scales by >>> SHIFT
// and hands the result to the activation stage with ready_signal.
// Optional build macro: ACC_SAT_EN (saturating accumulate and bias add).
module neuron_mac #(
  parameter int WIDTH    = 32,
  parameter int N_INPUTS = 64,
  parameter int SHIFT    = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              x_in,
  input  logic [7:0]              w_in,
  input  logic [7:0]              bias,
  input  logic [1:0]              ctrl_data,
  output logic signed [WIDTH-1:0] acc_out,
  output logic                    ready_signal,
  output logic                    busy
);

  localparam int CW = $clog2(N_INPUTS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_INPUTS - 1);

`ifdef ACC_SAT_EN
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shared adder for accumulate and bias add; clamps on signed overflow
  // when saturation is built in, otherwise wraps modulo 2^WIDTH.
  function automatic logic signed [WIDTH-1:0] acc_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] s;
    s = a + b;
`ifdef ACC_SAT_EN
    if ((a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1])) begin
      s = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`endif
    return s;
  endfunction

  state_t                  state_r;
  logic signed [WIDTH-1:0] acc_r;
  logic [CW-1:0]           count_r;

  logic signed [15:0]      prod_s;
  logic signed [WIDTH-1:0] prod_ext_s;
  logic signed [WIDTH-1:0] bias_ext_s;
  logic signed [WIDTH-1:0] acc_next_s;
  logic signed [WIDTH-1:0] bias_sum_s;
  logic signed [WIDTH-1:0] scaled_s;
  logic                    beat_s;

  assign prod_s     = $signed(x_in) * $signed(w_in);
  assign prod_ext_s = WIDTH'(prod_s);
  assign bias_ext_s = WIDTH'($signed(bias));
  assign acc_next_s = acc_add(acc_r, prod_ext_s);
  assign bias_sum_s = acc_add(acc_r, bias_ext_s);
  assign scaled_s   = bias_sum_s >>> SHIFT;
  assign beat_s     = in_valid && in_ready;

  // Control FSM with accumulator, beat counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      acc_r        <= {WIDTH{1'b0}};
      count_r      <= {CW{1'b0}};
      acc_out      <= {WIDTH{1'b0}};
      ready_signal <= 1'b0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r      <= ACCUM;
            acc_r        <= {WIDTH{1'b0}};
            count_r      <= {CW{1'b0}};
            ready_signal <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat_s) begin
            acc_r   <= acc_next_s;
            count_r <= count_r + CW'(1);
            if (count_r == LAST_IDX) begin
              state_r  <= BIAS;
              in_ready <= 1'b0;
            end
          end
        end
        BIAS: begin
          acc_out      <= ctrl_data[1] ? bias_sum_s : scaled_s;
          ready_signal <= 1'b1;
          busy         <= 1'b0;
          state_r      <= DONE;
        end
        default: begin
          state_r      <= IDLE;
          ready_signal <= 1'b0;
          in_ready     <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: a WIDTH=18 and a WIDTH=16 instance
// (N_INPUTS=4) share stimulus; expected results are queued per neuron and
// compared when ready_signal rises.
module tb_neuron_mac;

  localparam int N  = 4;
  localparam int SH = 9;

  logic clk, rst_n, start, in_valid;
  logic [7:0] x_in, w_in, bias;
  logic [1:0] ctrl_data;
  logic in_ready_a, ready_a, busy_a;
  logic in_ready_b, ready_b, busy_b;
  logic signed [17:0] acc_a;
  logic signed [15:0] acc_b;

  neuron_mac #(.WIDTH(18), .N_INPUTS(N), .SHIFT(SH)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_a), .x_in(x_in), .w_in(w_in), .bias(bias),
    .ctrl_data(ctrl_data), .acc_out(acc_a), .ready_signal(ready_a), .busy(busy_a)
  );

  neuron_mac #(.WIDTH(16), .N_INPUTS(N), .SHIFT(SH)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_b), .x_in(x_in), .w_in(w_in), .bias(bias),
    .ctrl_data(ctrl_data), .acc_out(acc_b), .ready_signal(ready_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint a; longint b; } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int xs_g[4];
  int ws_g[4];
  int bias_g;
  logic [1:0] cd_g;
  longint last_a, last_b;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint addw(input longint a, input longint b, input int w);
    longint r, lim;
    r   = a + b;
    lim = longint'(1) <<< w;
`ifdef ACC_SAT_EN
    if (r > (lim / 2) - 1) r = (lim / 2) - 1;
    else if (r < -(lim / 2)) r = -(lim / 2);
`else
    r = r & (lim - 1);
    if (r >= lim / 2) r = r - lim;
`endif
    return r;
  endfunction

  function automatic longint model(input int w);
    longint acc;
    acc = 0;
    for (int k = 0; k < N; k++) acc = addw(acc, longint'(xs_g[k] * ws_g[k]), w);
    acc = addw(acc, longint'(bias_g), w);
    if (!cd_g[1]) acc = acc >>> SH;
    return acc;
  endfunction

  // One neuron: queue expectation, start, feed beats per valid pattern
  // (LSB first), check handshake/latency, then pop and compare.
  task automatic run(input string tag, input logic [7:0] vpat, input int plen,
                     input int spos, input bit extra);
    exp_t e;
    int k;
    e.a = model(18);
    e.b = model(16);
    sb_q.push_back(e);
    bias      = 8'(bias_g);
    ctrl_data = cd_g;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_rdy_fall"}, ready_a, 0);
    chk({tag, "_inrdy_acc"}, in_ready_a, 1);
    chk({tag, "_busy_acc"}, busy_a, 1);
    k = 0;
    for (int i = 0; i < plen; i++) begin
      start    = (i == spos);
      in_valid = vpat[i];
      if (vpat[i]) begin
        x_in = 8'(xs_g[k]);
        w_in = 8'(ws_g[k]);
      end else begin
        x_in = 8'($urandom);
        w_in = 8'($urandom);
      end
      step();
      start = 1'b0;
      if (vpat[i]) k++;
      if (i == spos) begin
        chk({tag, "_start_ign_inrdy"}, in_ready_a, 1);
        chk({tag, "_start_ign_rdy"}, ready_a, 0);
      end
    end
    in_valid = extra;
    x_in = 8'($urandom);
    w_in = 8'($urandom);
    chk({tag, "_lat0_rdy"}, ready_a, 0);
    chk({tag, "_bias_inrdy"}, in_ready_a, 0);
    step();
    chk({tag, "_lat1_rdy"}, ready_a, 1);
    chk({tag, "_lat1_rdy_b"}, ready_b, 1);
    chk({tag, "_done_inrdy"}, in_ready_a, 0);
    chk({tag, "_done_busy"}, busy_a, 0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_acc_a"}, acc_a, e.a);
      chk({tag, "_acc_b"}, acc_b, e.b);
      last_a = e.a;
      last_b = e.b;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    x_in = 8'd0; w_in = 8'd0; bias = 8'd0; ctrl_data = 2'b00;
    step(); step();
    chk("rst_acc", acc_a, 0);
    chk("rst_rdy", ready_a, 0);
    chk("rst_inrdy", in_ready_a, 0);
    chk("rst_busy", busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_inrdy", in_ready_a, 0);

    // Basic sum, back-to-back beats.
    xs_g = '{10, 20, -5, 3};
    ws_g = '{2, 1, 4, -1};
    bias_g = 5; cd_g = 2'b10;
    run("basic", 8'h0F, 4, -1, 1'b0);

    // Scaling, positive and negative extremes.
    xs_g = '{127, 127, 127, 127};
    ws_g = '{127, 127, 127, 127};
    bias_g = 0; cd_g = 2'b00;
    run("scale_pos", 8'h0F, 4, -1, 1'b0);
    xs_g = '{-128, -128, -128, -128};
    cd_g = 2'b01;
    run("scale_neg", 8'h0F, 4, -1, 1'b0);

    // Stalls 1,0,0,1,1,0,1 and extra beats offered in BIAS/DONE.
    xs_g = '{10, 20, -5, 3};
    ws_g = '{2, 1, 4, -1};
    bias_g = 5; cd_g = 2'b11;
    run("stall", 8'h59, 7, -1, 1'b1);
    chk("stall_extra_inrdy", in_ready_a, 0);

    // Start during ACCUM ignored; then DONE hold.
    xs_g = '{-7, 33, 100, -128};
    ws_g = '{9, -2, 50, -128};
    bias_g = -20; cd_g = 2'b10;
    run("start_ign", 8'h1B, 5, 2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bias      = 8'($urandom);
      ctrl_data = 2'($urandom);
      in_valid  = 1'($urandom);
      step();
      chk("hold_acc", acc_a, last_a);
      chk("hold_rdy", ready_a, 1);
    end
    in_valid = 1'b0;

    // Next neuron after DONE starts from zero.
    xs_g = '{1, 2, 3, 4};
    ws_g = '{1, 1, 1, 1};
    bias_g = 0; cd_g = 2'b10;
    run("restart", 8'h0F, 4, -1, 1'b0);

    // Asynchronous reset mid-ACCUM after two beats.
    xs_g = '{100, 100, 100, 100};
    ws_g = '{100, 100, 100, 100};
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; x_in = 8'd100; w_in = 8'd100;
    step(); step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc", acc_a, 0);
    chk("arst_rdy", ready_a, 0);
    chk("arst_inrdy", in_ready_a, 0);
    chk("arst_busy", busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    xs_g = '{10, 20, -5, 3};
    ws_g = '{2, 1, 4, -1};
    bias_g = 5; cd_g = 2'b10;
    run("after_rst", 8'h0F, 4, -1, 1'b0);

    // Overflow: fits in 18 bits, wraps or saturates in 16 bits.
    xs_g = '{127, 127, 127, 127};
    ws_g = '{127, 127, 127, 127};
    bias_g = 0; cd_g = 2'b10;
    run("ovf", 8'h0F, 4, -1, 1'b0);
    chk("ovf_a_const", acc_a, 64516);
`ifdef ACC_SAT_EN
    chk("ovf_b_const", acc_b, 32767);
`else
    chk("ovf_b_const", acc_b, -1020);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
